// File: rtl/ltf_freq_seq_gen.sv
// ltf_freq_seq_gen
//   Streams frequency-domain long-training-field coefficients, one subcarrier
//   per beat, into the pipelined IFFT. Handles L-LTF (always two symbols) and
//   HT-LTF (1/2/4 symbols, P-matrix row-0 sign applied per symbol). The output
//   is a valid/ready stream with back-pressure.
//
// Ports
//   clk           tx clock
//   phy_tx_arest  asynchronous, active-high reset
//   start         request a sequence (sampled only in IDLE)
//   mode          0 = L-LTF, 1 = HT-LTF (latched at start)
//   n_ltf_sel     HT-LTF symbol count 0->1, 1->2, 2/3->4 (latched at start)
//   abort         synchronous abort, wins over start
//   dout          {I, Q} coefficient, Q always 0
//   dout_valid    dout holds a coefficient
//   dout_ready    downstream accepts the beat when dout_valid & dout_ready
//   dout_sc_idx   index of the current beat within its symbol
//   dout_last_sc  current beat is the last subcarrier of a symbol
//   dout_last     current beat is the final beat of the sequence
//   busy          state != IDLE
//   done          one-cycle pulse after the final beat is accepted
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// RUN   | presenting beats; advances on every accepted beat
// DONE  | final beat accepted; done high for this one cycle
module ltf_freq_seq_gen #(
    parameter int              IQ_W  = 16,
    parameter logic [IQ_W-1:0] AMP   = 16'h4000,
    parameter int              N_SC  = 64,
    localparam int             IDX_W = $clog2(N_SC)
) (
    input  logic              clk,
    input  logic              phy_tx_arest,
    input  logic              start,
    input  logic              mode,
    input  logic [1:0]        n_ltf_sel,
    input  logic              abort,
    output logic [2*IQ_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [IDX_W-1:0]  dout_sc_idx,
    output logic              dout_last_sc,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Coefficient code: bit0 = non-zero, bit1 = negative.
    localparam logic [1:0] CP = 2'b01;
    localparam logic [1:0] CM = 2'b11;
    localparam logic [1:0] CZ = 2'b00;

    // L-LTF values for s = -26..26 (entry j is subcarrier j-26).
    localparam logic [1:0] L_TBL [0:52] = '{
        CP, CP, CM, CM, CP, CP, CM, CP, CM, CP,
        CP, CP, CP, CP, CP, CM, CM, CP, CP, CM,
        CP, CM, CP, CP, CP, CP,
        CZ,
        CP, CM, CM, CP, CP, CM, CP, CM, CP, CM,
        CM, CM, CM, CM, CP, CP, CM, CM, CP, CM,
        CP, CM, CP, CP, CP, CP
    };

    function automatic logic [1:0] coef_of(input logic [IDX_W-1:0] i, input logic ht);
        int s;
        s = int'(i) - N_SC / 2;
        if (s >= -26 && s <= 26)
            return L_TBL[6'(s + 26)];
        else if (ht && (s == -28 || s == -27))
            return CP;
        else if (ht && (s == 27 || s == 28))
            return CM;
        else
            return CZ;
    endfunction

    state_t            state;
    logic              ht_q;
    logic [1:0]        sym_q;
    logic [1:0]        last_sym_q;

    logic [IDX_W-1:0]  nxt_idx;
    logic [1:0]        nxt_sym;
    logic              nxt_ht;
    logic [1:0]        nxt_last_sym;
    logic [1:0]        nxt_coef;
    logic              nxt_neg;
    logic [IQ_W-1:0]   nxt_i;
    logic [2*IQ_W-1:0] nxt_dout;
    logic              nxt_last_sc;
    logic              nxt_last;

    // Describes the beat that will be presented after the next load: the
    // first beat of a new sequence when idle, otherwise the successor of the
    // beat currently on dout.
    always_comb begin
        nxt_idx      = dout_sc_idx + IDX_W'(1);
        nxt_sym      = (dout_sc_idx == IDX_W'(N_SC - 1)) ? sym_q + 2'd1 : sym_q;
        nxt_ht       = ht_q;
        nxt_last_sym = last_sym_q;
        if (state == S_IDLE) begin
            nxt_idx = '0;
            nxt_sym = '0;
            nxt_ht  = mode;
            if (!mode)
                nxt_last_sym = 2'd1;
            else if (n_ltf_sel == 2'd0)
                nxt_last_sym = 2'd0;
            else if (n_ltf_sel == 2'd1)
                nxt_last_sym = 2'd1;
            else
                nxt_last_sym = 2'd3;
        end
        nxt_coef = coef_of(nxt_idx, nxt_ht);
        // P0 = {+1,-1,+1,+1}: only HT symbol 1 is inverted.
        nxt_neg  = nxt_coef[1] ^ (nxt_ht && nxt_sym == 2'd1);
        if (!nxt_coef[0])
            nxt_i = '0;
        else if (nxt_neg)
            nxt_i = -AMP;
        else
            nxt_i = AMP;
        nxt_dout    = {nxt_i, {IQ_W{1'b0}}};
        nxt_last_sc = (nxt_idx == IDX_W'(N_SC - 1));
        nxt_last    = nxt_last_sc && (nxt_sym == nxt_last_sym);
    end

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            state        <= S_IDLE;
            ht_q         <= 1'b0;
            sym_q        <= '0;
            last_sym_q   <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_sc_idx  <= '0;
            dout_last_sc <= 1'b0;
            dout_last    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state        <= S_RUN;
                        busy         <= 1'b1;
                        ht_q         <= nxt_ht;
                        last_sym_q   <= nxt_last_sym;
                        sym_q        <= nxt_sym;
                        dout_sc_idx  <= nxt_idx;
                        dout         <= nxt_dout;
                        dout_last_sc <= nxt_last_sc;
                        dout_last    <= nxt_last;
                        dout_valid   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort || (dout_ready && dout_last)) begin
                        // Both exits clear the beat; only normal completion pulses done.
                        state        <= abort ? S_IDLE : S_DONE;
                        busy         <= !abort;
                        done         <= !abort;
                        sym_q        <= '0;
                        dout         <= '0;
                        dout_valid   <= 1'b0;
                        dout_sc_idx  <= '0;
                        dout_last_sc <= 1'b0;
                        dout_last    <= 1'b0;
                    end else if (dout_ready) begin
                        sym_q        <= nxt_sym;
                        dout_sc_idx  <= nxt_idx;
                        dout         <= nxt_dout;
                        dout_last_sc <= nxt_last_sc;
                        dout_last    <= nxt_last;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltf_freq_seq_gen.sv
module tb_ltf_freq_seq_gen;

    logic        clk = 1'b0;
    logic        phy_tx_arest = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  n_ltf_sel = 2'd0;
    logic        abort = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [5:0]  dout_sc_idx;
    logic        dout_last_sc;
    logic        dout_last;
    logic        busy;
    logic        done;

    ltf_freq_seq_gen dut (
        .clk          (clk),
        .phy_tx_arest (phy_tx_arest),
        .start        (start),
        .mode         (mode),
        .n_ltf_sel    (n_ltf_sel),
        .abort        (abort),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_sc_idx  (dout_sc_idx),
        .dout_last_sc (dout_last_sc),
        .dout_last    (dout_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // 802.11 L-LTF for s = -26..26
    string lseq = "++--++-+-++++++--++-+-++++0+--++-+-+-----++--+-+-++++";

    logic [31:0] cap_dout [0:299];
    logic [5:0]  cap_idx  [0:299];
    logic        cap_lsc  [0:299];
    logic        cap_last [0:299];
    logic [31:0] ref_dout [0:255];
    int n_cap, done_cnt, done_cyc, last_cyc, first_cyc, unstable, timed_out;

    function automatic logic [31:0] exp_coef(input int idx, input int sym, input bit ht);
        int  s;
        int  v;
        byte ch;
        s = idx - 32;
        v = 0;
        if (s >= -26 && s <= 26) begin
            ch = lseq[s + 26];
            v = (ch == 8'h2B) ? 1 : (ch == 8'h2D) ? -1 : 0;
        end else if (ht && (s == -28 || s == -27)) begin
            v = 1;
        end else if (ht && (s == 27 || s == 28)) begin
            v = -1;
        end
        if (ht && sym == 1) v = -v;
        return (v == 1) ? 32'h4000_0000 : (v == -1) ? 32'hC000_0000 : 32'h0;
    endfunction

    task automatic do_start(input bit md, input logic [1:0] sel);
        @(posedge clk);
        #1;
        mode = md;
        n_ltf_sel = sel;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observes the stream until a few cycles past done; records beats only.
    task automatic collect(input bit rnd, input int pulse_c);
        int c;
        bit fin;
        bit held;
        logic [31:0] h_d;
        logic [5:0]  h_i;
        logic        h_l, h_s;
        n_cap = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; first_cyc = -1;
        unstable = 0; timed_out = 1;
        held = 0; fin = 0; c = 0;
        h_d = '0; h_i = '0; h_l = 0; h_s = 0;
        while (!fin && c < 2000) begin
            @(negedge clk);
            if (held && (!dout_valid || dout !== h_d || dout_sc_idx !== h_i ||
                         dout_last !== h_l || dout_last_sc !== h_s))
                unstable++;
            if (dout_valid && first_cyc < 0) first_cyc = c;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (dout_valid && dout_ready) begin
                if (n_cap < 300) begin
                    cap_dout[n_cap] = dout;
                    cap_idx[n_cap]  = dout_sc_idx;
                    cap_lsc[n_cap]  = dout_last_sc;
                    cap_last[n_cap] = dout_last;
                end
                n_cap++;
                if (dout_last) last_cyc = c;
            end
            held = dout_valid && !dout_ready;
            h_d = dout; h_i = dout_sc_idx; h_l = dout_last; h_s = dout_last_sc;
            if (done_cyc >= 0 && c >= done_cyc + 4) begin
                fin = 1;
                timed_out = 0;
            end
            @(posedge clk);
            #1;
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == pulse_c) begin
                start = 1'b1;
                mode = 1'b1;
                n_ltf_sel = 2'd3;
            end else begin
                start = 1'b0;
            end
            c++;
        end
        dout_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        #1;
        outs = {dout_valid, dout, dout_sc_idx, dout_last_sc, dout_last, busy, done};
        vectors++;
        if (outs !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        repeat (2) @(negedge clk);
        phy_tx_arest = 1'b0;
        @(negedge clk);
        outs = {dout_valid, dout, dout_sc_idx, dout_last_sc, dout_last, busy, done};
        vectors++;
        if (outs !== 41'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h want 0", outs);
        end
    endtask

    task automatic test_lltf();
        int bad;
        do_start(1'b0, 2'd0);
        collect(1'b0, -1);
        vectors++;
        if (timed_out !== 0) begin
            miscompares++;
            $display("FAIL lltf_timeout: timed_out=%0d want 0", timed_out);
        end
        vectors++;
        if (n_cap !== 128) begin
            miscompares++;
            $display("FAIL lltf_beats: got %0d want 128", n_cap);
        end
        vectors++;
        if (first_cyc !== 0) begin
            miscompares++;
            $display("FAIL lltf_latency: first valid cycle %0d want 0", first_cyc);
        end
        vectors++;
        if (cap_dout[6] !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL lltf_idx6: got %h want 40000000", cap_dout[6]);
        end
        vectors++;
        if (cap_dout[32] !== 32'h0) begin
            miscompares++;
            $display("FAIL lltf_idx32: got %h want 0", cap_dout[32]);
        end
        vectors++;
        if (cap_dout[38] !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL lltf_idx38: got %h want c0000000", cap_dout[38]);
        end
        vectors++;
        if (last_cyc !== 127) begin
            miscompares++;
            $display("FAIL lltf_no_bubbles: last beat cycle %0d want 127", last_cyc);
        end
        vectors++;
        if (done_cyc !== last_cyc + 1 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL lltf_done: done cycle %0d count %0d want %0d count 1",
                     done_cyc, done_cnt, last_cyc + 1);
        end
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (cap_dout[i] !== exp_coef(i % 64, i / 64, 1'b0) || cap_idx[i] !== 6'(i % 64) ||
                cap_lsc[i] !== ((i % 64) == 63) || cap_last[i] !== (i == 127))
                bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL lltf_stream: %0d bad beats want 0", bad);
        end
    endtask

    task automatic test_htltf();
        int bad;
        int bad_lsc;
        do_start(1'b1, 2'd2);
        collect(1'b0, -1);
        vectors++;
        if (n_cap !== 256) begin
            miscompares++;
            $display("FAIL ht_beats: got %0d want 256", n_cap);
        end
        vectors++;
        if (cap_dout[68] !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL ht_sym1_idx4: got %h want c0000000", cap_dout[68]);
        end
        vectors++;
        if (cap_dout[4] !== 32'h4000_0000 || cap_dout[132] !== 32'h4000_0000 ||
            cap_dout[196] !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL ht_idx4_pos: got %h %h %h want 40000000 x3",
                     cap_dout[4], cap_dout[132], cap_dout[196]);
        end
        vectors++;
        if (cap_dout[60] !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL ht_sym0_idx60: got %h want c0000000", cap_dout[60]);
        end
        bad = 0;
        bad_lsc = 0;
        for (int i = 0; i < 256; i++) begin
            ref_dout[i] = cap_dout[i];
            if (cap_dout[i] !== exp_coef(i % 64, i / 64, 1'b1) || cap_last[i] !== (i == 255))
                bad++;
            if (cap_lsc[i] !== ((i % 64) == 63)) bad_lsc++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL ht_stream: %0d bad beats want 0", bad);
        end
        vectors++;
        if (bad_lsc !== 0) begin
            miscompares++;
            $display("FAIL ht_last_sc: %0d bad flags want 0", bad_lsc);
        end
    endtask

    task automatic test_symbol_counts();
        bit         md  [0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] sel [0:3] = '{2'd0, 2'd1, 2'd3, 2'd3};
        int         exp [0:3] = '{64, 128, 256, 128};
        for (int k = 0; k < 4; k++) begin
            do_start(md[k], sel[k]);
            collect(1'b0, -1);
            vectors++;
            if (n_cap !== exp[k] || (n_cap > 0 && n_cap <= 300 && cap_last[n_cap - 1] !== 1'b1)) begin
                miscompares++;
                $display("FAIL sym_count_%0d: got %0d beats want %0d", k, n_cap, exp[k]);
            end
        end
    endtask

    task automatic test_random_ready();
        int bad;
        do_start(1'b1, 2'd2);
        collect(1'b1, -1);
        vectors++;
        if (n_cap !== 256) begin
            miscompares++;
            $display("FAIL rnd_beats: got %0d want 256", n_cap);
        end
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (cap_dout[i] !== ref_dout[i]) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL rnd_stream: %0d beats differ want 0", bad);
        end
        vectors++;
        if (unstable !== 0) begin
            miscompares++;
            $display("FAIL rnd_hold_stable: %0d unstable cycles want 0", unstable);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL rnd_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_abort();
        bit found;
        int seen_done;
        int seen_valid;
        found = 0;
        do_start(1'b1, 2'd2);
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (dout_valid && dout_sc_idx == 6'd40) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL abort_reach_beat40: not reached want reached");
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        vectors++;
        if ({dout_valid, busy, dout_sc_idx} !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_clear: valid=%b busy=%b idx=%0d want 0 0 0",
                     dout_valid, busy, dout_sc_idx);
        end
        seen_done = 0;
        seen_valid = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) seen_done++;
            if (dout_valid) seen_valid++;
        end
        vectors++;
        if (seen_done !== 0 || seen_valid !== 0) begin
            miscompares++;
            $display("FAIL abort_quiet: done=%0d valid=%0d want 0 0", seen_done, seen_valid);
        end
        do_start(1'b1, 2'd2);
        collect(1'b0, -1);
        vectors++;
        if (n_cap !== 256 || first_cyc !== 0 || cap_idx[0] !== 6'd0 ||
            cap_dout[4] !== 32'h4000_0000 || cap_dout[68] !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL abort_restart: beats %0d idx0 %0d d4 %h d68 %h want 256 0 40000000 c0000000",
                     n_cap, cap_idx[0], cap_dout[4], cap_dout[68]);
        end
    endtask

    task automatic test_async_reset();
        logic [40:0] outs;
        int seen_done;
        do_start(1'b1, 2'd2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dout_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_precond: valid=%b busy=%b want 1 1", dout_valid, busy);
        end
        #2;
        phy_tx_arest = 1'b1;
        #1;
        outs = {dout_valid, dout, dout_sc_idx, dout_last_sc, dout_last, busy, done};
        vectors++;
        if (outs !== 41'd0) begin
            miscompares++;
            $display("FAIL arst_immediate: got %h want 0", outs);
        end
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        phy_tx_arest = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done || dout_valid) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL arst_no_done: got %0d want 0", seen_done);
        end
        do_start(1'b0, 2'd0);
        collect(1'b0, -1);
        vectors++;
        if (n_cap !== 128 || first_cyc !== 0 || cap_dout[38] !== 32'hC000_0000 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL arst_restart: beats %0d first %0d d38 %h done %0d want 128 0 c0000000 1",
                     n_cap, first_cyc, cap_dout[38], done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        int seen;
        do_start(1'b0, 2'd0);
        collect(1'b0, 10);
        mode = 1'b0;
        n_ltf_sel = 2'd0;
        bad = 0;
        for (int i = 0; i < 128 && i < n_cap; i++)
            if (cap_dout[i] !== exp_coef(i % 64, i / 64, 1'b0)) bad++;
        vectors++;
        if (n_cap !== 128 || done_cnt !== 1 || bad !== 0) begin
            miscompares++;
            $display("FAIL start_in_run: beats %0d done %0d bad %0d want 128 1 0", n_cap, done_cnt, bad);
        end
        do_start(1'b0, 2'd0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dout_valid || done || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL start_abort_run: %0d active cycles want 0", seen);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (dout_valid || done || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL start_abort_idle: %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_lltf();
        test_htltf();
        test_symbol_counts();
        test_random_ready();
        test_abort();
        test_async_reset();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
